pll_lock_sequencer: RTL

Reset/lock supervisor on the reference-clock side of the pixel-clock PLL. It drives the PLL's active-low reset and watches the PLL lock output. It releases the renderer's system reset only after lock has been stable for a programmed time. It re-sequences on lock loss, and latches a fault after repeated lock timeouts.

---
 rtl/pll_lock_sequencer_if.sv | 17 +
 rtl/pll_lock_sequencer.sv | 94 +++++++++
 2 files changed

// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if: PLL lock/reset and status signals between the sequencer (master) and its PLL/system side (slave).
interface pll_lock_sequencer_if;
  logic       PLL_LOCK;
  logic       PLL_RESETB;
  logic       SYS_RESET_N;
  logic       FAULT;
  logic [1:0] RETRY_COUNT;
  logic [7:0] LOCK_LOSS_COUNT;
  modport master (
    input  PLL_LOCK,
    output PLL_RESETB, SYS_RESET_N, FAULT, RETRY_COUNT, LOCK_LOSS_COUNT
  );
  modport slave (
    output PLL_LOCK,
    input  PLL_RESETB, SYS_RESET_N, FAULT, RETRY_COUNT, LOCK_LOSS_COUNT
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: holds the PLL in reset, waits for stable lock, then releases system reset; PLL_SEQ_LOSS_COUNTER_EN builds the lock-loss counter.
module pll_lock_sequencer #(
  parameter int HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT  = 12000,
  parameter int STABLE_CYCLES = 1200,
  parameter int MAX_RETRIES   = 3
) (
  input logic REFERENCECLK,
  input logic RESET,
  pll_lock_sequencer_if.master bus
);
  localparam int MAX_HT = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P = (MAX_HT > STABLE_CYCLES) ? MAX_HT : STABLE_CYCLES;
  localparam int CW = $clog2(MAX_P + 1);
  if (HOLD_CYCLES < 2 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 2 || MAX_RETRIES < 1 || MAX_RETRIES > 3) begin : g_bad_params
    $error("pll_lock_sequencer: parameter out of range");
  end
  typedef enum logic [2:0] {ST_HOLD, ST_WAIT, ST_SETTLE, ST_RUN, ST_FAULT} state_e;
  state_e        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sync_q, rc_q, rc_d;
  logic          prb_q, srn_q, fault_q, lock_s;
  assign lock_s = sync_q[1];
  assign cnt_d  = cnt_q + 1'b1;
  assign rc_d   = rc_q + 2'd1;
  assign bus.PLL_RESETB  = prb_q;
  assign bus.SYS_RESET_N = srn_q;
  assign bus.FAULT       = fault_q;
  assign bus.RETRY_COUNT = rc_q;
`ifdef PLL_SEQ_LOSS_COUNTER_EN
  logic [7:0] llc_q, llc_d;
  assign llc_d = (llc_q == 8'hff) ? llc_q : llc_q + 8'd1;
  assign bus.LOCK_LOSS_COUNT = llc_q;
`else
  assign bus.LOCK_LOSS_COUNT = 8'd0;
`endif
  // SETTLE entry already consumed one locked sample, so it counts STABLE_CYCLES-1 more
  always_ff @(posedge REFERENCECLK) begin
    if (!RESET) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      sync_q  <= '0;
      prb_q   <= 1'b0;
      srn_q   <= 1'b0;
      fault_q <= 1'b0;
      rc_q    <= '0;
`ifdef PLL_SEQ_LOSS_COUNTER_EN
      llc_q   <= '0;
`endif
    end else begin
      sync_q <= {sync_q[0], bus.PLL_LOCK};
      case (state_q)
        ST_HOLD:
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            prb_q   <= 1'b1;
          end else cnt_q <= cnt_d;
        ST_WAIT:
          if (lock_s) begin
            state_q <= ST_SETTLE;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
            state_q <= (rc_d == 2'(MAX_RETRIES)) ? ST_FAULT : ST_HOLD;
            fault_q <= rc_d == 2'(MAX_RETRIES);
            cnt_q   <= '0;
            rc_q    <= rc_d;
            prb_q   <= 1'b0;
          end else cnt_q <= cnt_d;
        ST_SETTLE:
          if (!lock_s) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(STABLE_CYCLES - 2)) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            srn_q   <= 1'b1;
            rc_q    <= '0;
          end else cnt_q <= cnt_d;
        ST_RUN:
          if (!lock_s) begin
            state_q <= ST_HOLD;
            srn_q   <= 1'b0;
            prb_q   <= 1'b0;
`ifdef PLL_SEQ_LOSS_COUNTER_EN
            llc_q   <= llc_d;
`endif
          end
        ST_FAULT: ;
        default: state_q <= ST_HOLD;
      endcase
    end
  end
endmodule
